// File: rtl/user_code_entry_pkg.sv
// Shared types and helpers for the user code entry front end.
// Optional feature macro: USER_ENTRY_DEBOUNCE_EN (button synchronizer + debouncer).
package user_code_entry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_CHECK   = 3'd2,
    ST_GRANTED = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  localparam int CODE_W_DEF = 3;
  localparam int DBNC_CNT   = 16;
  localparam int DBNC_W     = 4;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int tmr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/user_code_entry_btn_edge.sv
// One push-button: optional sync/debounce, then a rising-edge press pulse.
// With USER_ENTRY_DEBOUNCE_EN defined the level passes a 2-flop sync and a 16-sample debouncer.
module user_code_entry_btn_edge
  import user_code_entry_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic btn_i,
  output logic press_o
);

  logic level;
  logic hist_q;

`ifdef USER_ENTRY_DEBOUNCE_EN
  logic [1:0]        sync_q;
  logic              stable_q;
  logic [DBNC_W-1:0] cnt_q;

  // Everything resets high so a button held through reset never looks like a press.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      if (sync_q[1] != stable_q) begin
        if (cnt_q == DBNC_W'(DBNC_CNT - 1)) begin
          stable_q <= sync_q[1];
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + DBNC_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level = stable_q;
`else
  assign level = btn_i;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) hist_q <= 1'b1;
    else        hist_q <= level;
  end

  assign press_o = level & ~hist_q;

endmodule

// File: rtl/user_code_entry.sv
// Collects a bit-serial user code from two buttons, strobes it to the authentication
// block, then holds the granted profile or locks out after repeated failures.
module user_code_entry
  import user_code_entry_pkg::*;
#(
  parameter int CODE_W      = CODE_W_DEF,
  parameter int TIMEOUT_CYC = 1000,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYC    = 2000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              BTN_0,
  input  logic              BTN_1,
  input  logic              BTN_CLR,
  input  logic              V_IN,
  input  logic [CODE_W-1:0] CK_U_IN,
  output logic [CODE_W-1:0] U,
  output logic              REQ,
  output logic [CODE_W-1:0] PROFILE,
  output logic              LOGGED,
  output logic              LOCKED,
  output logic [1:0]        DIGITS
);

  localparam int TMO_W  = tmr_w(TIMEOUT_CYC);
  localparam int LCK_W  = tmr_w(LOCK_CYC);
  localparam int FAIL_W = tmr_w(MAX_FAIL + 1);

  logic [2:0] btn_lvl;
  logic [2:0] press;

  assign btn_lvl = {BTN_CLR, BTN_1, BTN_0};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    user_code_entry_btn_edge u_btn (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .btn_i  (btn_lvl[gi]),
      .press_o(press[gi])
    );
  end

  // Simultaneous 0 and 1 presses are ambiguous and dropped.
  logic digit_ev, digit_bit, clr_ev;
  assign digit_ev  = press[0] ^ press[1];
  assign digit_bit = press[1];
  assign clr_ev    = press[2];

  state_e              state_q,   state_d;
  logic [CODE_W-1:0]   u_q,       u_d;
  logic [1:0]          digits_q,  digits_d;
  logic [CODE_W-1:0]   profile_q, profile_d;
  logic                logged_q,  logged_d;
  logic [FAIL_W-1:0]   fail_q,    fail_d;
  logic [TMO_W-1:0]    tmo_q,     tmo_d;
  logic [LCK_W-1:0]    lock_q,    lock_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      u_q       <= '0;
      digits_q  <= '0;
      profile_q <= '0;
      logged_q  <= 1'b0;
      fail_q    <= '0;
      tmo_q     <= '0;
      lock_q    <= '0;
    end else begin
      state_q   <= state_d;
      u_q       <= u_d;
      digits_q  <= digits_d;
      profile_q <= profile_d;
      logged_q  <= logged_d;
      fail_q    <= fail_d;
      tmo_q     <= tmo_d;
      lock_q    <= lock_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    u_d       = u_q;
    digits_d  = digits_q;
    profile_d = profile_q;
    logged_d  = logged_q;
    fail_d    = fail_q;
    tmo_d     = tmo_q;
    lock_d    = lock_q;

    unique case (state_q)
      ST_IDLE: begin
        u_d      = '0;
        digits_d = '0;
        if (!clr_ev && digit_ev) begin
          u_d      = CODE_W'(digit_bit);
          digits_d = 2'd1;
          tmo_d    = TMO_W'(TIMEOUT_CYC - 1);
          state_d  = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (clr_ev) begin
          u_d      = '0;
          digits_d = '0;
          state_d  = ST_IDLE;
        end else if (digit_ev) begin
          u_d      = {u_q[CODE_W-2:0], digit_bit};
          digits_d = digits_q + 2'd1;
          tmo_d    = TMO_W'(TIMEOUT_CYC - 1);
          if (digits_q + 2'd1 == 2'(CODE_W)) state_d = ST_CHECK;
        end else if (tmo_q == '0) begin
          u_d      = '0;
          digits_d = '0;
          state_d  = ST_IDLE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end

      // Single cycle with REQ high; the answer is taken at its closing edge.
      ST_CHECK: begin
        u_d      = '0;
        digits_d = '0;
        if (V_IN) begin
          profile_d = CK_U_IN;
          logged_d  = 1'b1;
          fail_d    = '0;
          state_d   = ST_GRANTED;
        end else begin
          fail_d = fail_q + FAIL_W'(1);
          if (fail_q + FAIL_W'(1) == FAIL_W'(MAX_FAIL)) begin
            lock_d  = LCK_W'(LOCK_CYC - 1);
            state_d = ST_LOCKOUT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_GRANTED: begin
        if (clr_ev) begin
          logged_d  = 1'b0;
          profile_d = '0;
          state_d   = ST_IDLE;
        end
      end

      ST_LOCKOUT: begin
        if (lock_q == '0) begin
          fail_d  = '0;
          state_d = ST_IDLE;
        end else begin
          lock_d = lock_q - LCK_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign U       = u_q;
  assign REQ     = (state_q == ST_CHECK);
  assign PROFILE = profile_q;
  assign LOGGED  = logged_q;
  assign LOCKED  = (state_q == ST_LOCKOUT);
  assign DIGITS  = digits_q;

endmodule

// File: tb/tb_user_code_entry.sv
// Directed bench for user_code_entry; inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_user_code_entry;

  localparam int CODE_W = 3;
  localparam int TMO    = 200;
  localparam int MAXF   = 3;
  localparam int LCK    = 300;

  logic              CLK     = 1'b0;
  logic              RST_N   = 1'b0;
  logic              BTN_0   = 1'b0;
  logic              BTN_1   = 1'b0;
  logic              BTN_CLR = 1'b0;
  logic              V_IN    = 1'b0;
  logic [CODE_W-1:0] CK_U_IN = '0;
  logic [CODE_W-1:0] U, PROFILE;
  logic              REQ, LOGGED, LOCKED;
  logic [1:0]        DIGITS;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0;

  user_code_entry #(
    .CODE_W(CODE_W), .TIMEOUT_CYC(TMO), .MAX_FAIL(MAXF), .LOCK_CYC(LCK)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN_0(BTN_0), .BTN_1(BTN_1), .BTN_CLR(BTN_CLR),
    .V_IN(V_IN), .CK_U_IN(CK_U_IN), .U(U), .REQ(REQ), .PROFILE(PROFILE),
    .LOGGED(LOGGED), .LOCKED(LOCKED), .DIGITS(DIGITS)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       BTN_0   = v;
      1:       BTN_1   = v;
      default: BTN_CLR = v;
    endcase
  endtask

  // Raise one button for a single cycle; returns just after the edge that sees the press.
  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick();
    set_btn(b, 1'b0);
  endtask

  // Three digits MSB first; returns in the CHECK cycle.
  task automatic enter(input logic [2:0] code);
    press(int'(code[2])); tick();
    press(int'(code[1])); tick();
    press(int'(code[0]));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_U", U, 0);
    check("rst_REQ", REQ, 0);
    check("rst_PROFILE", PROFILE, 0);
    check("rst_LOGGED", LOGGED, 0);
    check("rst_LOCKED", LOCKED, 0);
    check("rst_DIGITS", DIGITS, 0);
    RST_N = 1'b1;
    tick(); tick();

`ifdef USER_ENTRY_DEBOUNCE_EN
    repeat (40) tick();
    BTN_1 = 1'b1; repeat (5) tick(); BTN_1 = 1'b0;
    repeat (40) tick();
    check("dbnc_glitch_DIGITS", DIGITS, 0);
    BTN_1 = 1'b1; repeat (30) tick(); BTN_1 = 1'b0;
    repeat (40) tick();
    check("dbnc_press_DIGITS", DIGITS, 1);
    check("dbnc_press_U", U, 3'b001);
`else
    // Grant path
    enter(3'b111);
    check("g_REQ", REQ, 1);
    check("g_U", U, 3'b111);
    check("g_DIGITS", DIGITS, 3);
    check("g_LOGGED_early", LOGGED, 0);
    V_IN = 1'b1; CK_U_IN = 3'b101;
    tick();
    V_IN = 1'b0; CK_U_IN = '0;
    check("g_REQ_off", REQ, 0);
    check("g_LOGGED", LOGGED, 1);
    check("g_PROFILE", PROFILE, 3'b101);
    check("g_U_clr", U, 0);
    press(1); tick();
    check("g_digit_ignored", DIGITS, 0);
    press(2);
    check("g_logout_LOGGED", LOGGED, 0);
    check("g_logout_PROFILE", PROFILE, 0);
    tick();

    // Three wrong codes -> lockout
    for (int i = 0; i < 3; i++) begin
      tick();
      enter(3'b110);
      check("l_REQ", REQ, 1);
      check("l_U", U, 3'b110);
      tick();
      check("l_LOCKED", LOCKED, (i == 2) ? 1 : 0);
    end
    t0 = cyc;
    tick(); press(1); tick(); press(2); tick();
    check("l_press_DIGITS", DIGITS, 0);
    check("l_clr_ignored", LOCKED, 1);
    while (cyc - t0 < LCK - 3) tick();
    BTN_1 = 1'b1;
    while (cyc - t0 < LCK - 1) tick();
    check("l_still_locked", LOCKED, 1);
    tick();
    check("l_exit", LOCKED, 0);
    tick(); tick();
    check("l_held_btn_DIGITS", DIGITS, 0);
    BTN_1 = 1'b0;
    tick();
    enter(3'b110);
    tick();
    check("l_failcnt_cleared", LOCKED, 0);

    // Timeout discards a partial entry
    tick();
    press(0);
    check("t_DIGITS1", DIGITS, 1);
    repeat (TMO - 1) tick();
    check("t_before", DIGITS, 1);
    tick();
    check("t_DIGITS0", DIGITS, 0);
    check("t_U0", U, 0);
    tick();
    enter(3'b100);
    check("t_U100", U, 3'b100);
    V_IN = 1'b1; CK_U_IN = 3'b010;
    tick();
    V_IN = 1'b0; CK_U_IN = '0;
    check("t_LOGGED", LOGGED, 1);
    check("t_PROFILE", PROFILE, 3'b010);
    press(2); tick();

    // Simultaneous presses
    BTN_0 = 1'b1; BTN_1 = 1'b1; tick(); BTN_0 = 1'b0; BTN_1 = 1'b0;
    check("s_idle_both", DIGITS, 0);
    tick();
    press(1); tick();
    BTN_0 = 1'b1; BTN_1 = 1'b1; tick(); BTN_0 = 1'b0; BTN_1 = 1'b0;
    check("s_coll_both_DIGITS", DIGITS, 1);
    check("s_coll_both_U", U, 3'b001);
    tick();
    BTN_CLR = 1'b1; BTN_1 = 1'b1; tick(); BTN_CLR = 1'b0; BTN_1 = 1'b0;
    check("s_clr_DIGITS", DIGITS, 0);
    check("s_clr_U", U, 0);
    tick();

    // Reset mid-entry, then a button held through reset release
    press(1); tick(); press(0);
    check("r_DIGITS2", DIGITS, 2);
    check("r_U2", U, 3'b010);
    #2 RST_N = 1'b0;
    #1;
    check("r_async_DIGITS", DIGITS, 0);
    check("r_async_U", U, 0);
    BTN_1 = 1'b1;
    tick(); tick();
    RST_N = 1'b1;
    tick(); tick();
    check("r_held_DIGITS", DIGITS, 0);
    BTN_1 = 1'b0;
    tick();
    press(1);
    check("r_after_DIGITS", DIGITS, 1);
    check("r_after_U", U, 3'b001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/user_code_entry.md
Name: user_code_entry

Overview:
Front end of the authentication path. It collects a 3-bit user code entered bit-by-bit on two push-buttons and presents it as U with a one-cycle REQ strobe. It samples the authentication block's answer (V, CK_U) and then holds the granted profile, or counts failures and locks out after repeated invalid codes. Sits between the panel buttons and the authentication block.

Parameters:
CODE_W, 3, code width in bits; equals number of digit presses per attempt
TIMEOUT_CYC, 1000, idle cycles allowed between digit presses before the partial entry is discarded
MAX_FAIL, 3, consecutive invalid attempts that trigger lockout
LOCK_CYC, 2000, lockout duration in cycles

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
BTN_0  in  1  "enter 0" button, synchronous level
BTN_1  in  1  "enter 1" button, synchronous level
BTN_CLR  in  1  clear/logout button, synchronous level
V_IN  in  1  valid flag returned by authentication block
CK_U_IN  in  CODE_W  profile code returned by authentication block
U  out  CODE_W  assembled code presented to authentication block
REQ  out  1  one-cycle strobe: U complete, sample answer
PROFILE  out  CODE_W  granted profile, held while LOGGED
LOGGED  out  1  user authenticated
LOCKED  out  1  lockout active
DIGITS  out  2  digits entered in current attempt

Behaviour:
- Interface decision: one clock (CLK); reset RST_N is asynchronous and active-low.
- Reset values: U=0, REQ=0, PROFILE=0, LOGGED=0, LOCKED=0, DIGITS=0, fail count=0, timers=0, state=IDLE.
- Button edge-detect registers reset to 1, so a button held through reset release does not register a press.
- Press = rising edge (level 1 now, 0 last cycle).
- BTN_0 and BTN_1 edges in the same cycle: ignored, no shift.
- BTN_CLR edge has priority over digit edges in every state except LOCKOUT.
- Digits shift into U MSB-first: U <= {U[CODE_W-2:0], bit}. DIGITS increments per accepted digit.
- IDLE: U=0, DIGITS=0. A digit edge shifts in the bit, DIGITS=1, loads the timeout timer, then goes to COLLECT.
- COLLECT:
  - Each digit edge shifts in a bit, increments DIGITS and reloads the timer.
  - When the shift that makes DIGITS=CODE_W occurs, go to CHECK on the next edge.
  - Timer expiry after TIMEOUT_CYC cycles with no press: go to IDLE; U and DIGITS cleared; fail count unchanged.
  - BTN_CLR: go to IDLE, same clearing.
- CHECK (exactly 1 cycle): REQ=1, U stable. V_IN and CK_U_IN are sampled at the end of this cycle.
  - V_IN=1: PROFILE<=CK_U_IN, LOGGED<=1, fail count<=0, go to GRANTED.
  - V_IN=0: fail count +1. If the new count equals MAX_FAIL, go to LOCKOUT and load the lock timer; otherwise go to IDLE.
  - In both cases U and DIGITS are cleared.
- Latency: third press edge at cycle n; REQ=1 in cycle n+1; LOGGED/LOCKED valid in cycle n+2.
- GRANTED: digit edges are ignored. BTN_CLR edge causes logout: LOGGED=0, PROFILE=0, go to IDLE.
- LOCKOUT:
  - LOCKED=1; all buttons ignored, including BTN_CLR.
  - After LOCK_CYC cycles: LOCKED=0, fail count=0, go to IDLE.
  - Buttons held at lockout exit are not presses until released and re-pressed.
- REQ never asserts outside CHECK. REQ pulses are never back-to-back.
- Reset mid-operation (any state) returns immediately to reset values; partial code and lock are discarded.
- Counter widths use $clog2 of the parameter value; timers saturate, never wrap.

Optional Feature:
Macro: USER_ENTRY_DEBOUNCE_EN.
- Defined: each of BTN_0/BTN_1/BTN_CLR passes through a 2-flop synchronizer plus a stable-level debouncer. The debouncer takes a new level after 16 consecutive equal samples. Press detection uses the debounced levels, adding 18 cycles of latency per press.
- Undefined: buttons are used directly (already synchronous) with edge detect only.

Decomposition:
- Shared package: state encoding (IDLE, COLLECT, CHECK, GRANTED, LOCKOUT), CODE_W default, timer width helper.
- One sub-module, btn_edge: per-button optional sync/debounce plus rising-edge pulse, with the reset-to-1 history register. Instantiated three times.

Test Plan:
- Press 1,1,1 (one cycle apart); bench answers V_IN=1, CK_U_IN=3'b101 -> REQ pulse with U=3'b111, then LOGGED=1, PROFILE=3'b101; BTN_CLR -> LOGGED=0, PROFILE=0.
- Enter 1,1,0 three times with V_IN=0 -> three REQ pulses with U=3'b110; after the third, LOCKED=1. Presses during the lockout produce no DIGITS change. LOCKED=0 exactly LOCK_CYC cycles later.
- Press 0, then wait TIMEOUT_CYC cycles -> DIGITS returns to 0 and U=0. A following 1,0,0 yields U=3'b100.
- BTN_0 and BTN_1 rising in the same cycle -> DIGITS unchanged. BTN_CLR and BTN_1 together in COLLECT -> IDLE, DIGITS=0.
- BTN_1 held high across RST_N deassertion -> no press. Assert RST_N during COLLECT with DIGITS=2 -> all outputs return to 0 immediately.
- With USER_ENTRY_DEBOUNCE_EN: a 5-cycle glitch on BTN_1 -> no press; a 30-cycle press -> exactly one digit accepted.
